// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding imem requests and
// produces the IF/ID register, with a one-entry skid buffer for decode stalls.
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hz_bubble,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_ID_PC,
    output logic [31:0] IF_ID_Instr,
    output logic        IF_ID_valid
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        buf_valid_q, buf_valid_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic        if_valid_q, if_valid_d;

    logic        req_s;
    logic        grant_s;
    logic        resp_s;

    // Request/grant/response decode.
    always_comb begin
        req_s   = !rst && !redirect && !buf_valid_q &&
                  ((state_q == ST_REQ) ||
                   ((state_q == ST_WAIT) && imem_rvalid && !hz_bubble));
        grant_s = req_s && imem_gnt;
        resp_s  = (state_q == ST_WAIT) && imem_rvalid;
    end

    // Next-state logic for PC, fetch FSM, skid buffer and IF/ID.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        fetch_pc_d  = fetch_pc_q;
        buf_valid_d = buf_valid_q;
        buf_pc_d    = buf_pc_q;
        buf_instr_d = buf_instr_q;
        if_pc_d     = if_pc_q;
        if_instr_d  = if_instr_q;
        if_valid_d  = if_valid_q;

        if (redirect) begin
            pc_d        = redirect_pc;
            buf_valid_d = 1'b0;
            if_instr_d  = NOP_INSTR;
            if_valid_d  = 1'b0;
            // A response still owed by memory must be swallowed before refetching.
            if (((state_q == ST_WAIT) || (state_q == ST_DROP)) && !imem_rvalid) begin
                state_d = ST_DROP;
            end else begin
                state_d = ST_REQ;
            end
        end else begin
            if (grant_s) begin
                fetch_pc_d = pc_q;
                pc_d       = pc_q + 32'd4;
            end else begin
                fetch_pc_d = fetch_pc_q;
            end

            case (state_q)
                ST_REQ:  state_d = grant_s ? ST_WAIT : ST_REQ;
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        state_d = grant_s ? ST_WAIT : ST_REQ;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                ST_DROP: state_d = imem_rvalid ? ST_REQ : ST_DROP;
                default: state_d = ST_REQ;
            endcase

            if (hz_bubble) begin
                if (resp_s) begin
                    buf_valid_d = 1'b1;
                    buf_pc_d    = fetch_pc_q;
                    buf_instr_d = imem_rdata;
                end else begin
                    buf_valid_d = buf_valid_q;
                end
            end else if (buf_valid_q) begin
                if_pc_d     = buf_pc_q;
                if_instr_d  = buf_instr_q;
                if_valid_d  = 1'b1;
                buf_valid_d = 1'b0;
            end else if (resp_s) begin
                if_pc_d    = fetch_pc_q;
                if_instr_d = imem_rdata;
                if_valid_d = 1'b1;
            end else begin
                if_instr_d = NOP_INSTR;
                if_valid_d = 1'b0;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_REQ;
            pc_q        <= RESET_PC;
            fetch_pc_q  <= 32'h0000_0000;
            buf_valid_q <= 1'b0;
            buf_pc_q    <= 32'h0000_0000;
            buf_instr_q <= 32'h0000_0000;
            if_pc_q     <= 32'h0000_0000;
            if_instr_q  <= NOP_INSTR;
            if_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            fetch_pc_q  <= fetch_pc_d;
            buf_valid_q <= buf_valid_d;
            buf_pc_q    <= buf_pc_d;
            buf_instr_q <= buf_instr_d;
            if_pc_q     <= if_pc_d;
            if_instr_q  <= if_instr_d;
            if_valid_q  <= if_valid_d;
        end
    end

    assign imem_req    = req_s;
    assign imem_addr   = pc_q;
    assign IF_ID_PC    = if_pc_q;
    assign IF_ID_Instr = if_instr_q;
    assign IF_ID_valid = if_valid_q;

endmodule
